// File: rtl/eth_payload_byte_reader.sv
// eth_payload_byte_reader
// Reads ceil(len/4) 32-bit words from a prefetch FIFO and streams the
// packet payload out as bytes, most significant byte of each word first.
// Unused low bytes of a partial final word are dropped so every packet
// begins on a fresh word.
//
// Optional feature: define ETH_MIN_PAYLOAD_PAD_EN to append 8'h00 pad
// bytes after short packets (len < MIN_LEN) up to MIN_LEN bytes total.
//
// Handshakes (valid/ready): a FIFO pop happens on a cycle where
// fifo_rd_vld & fifo_rd_en; a byte transfers on a cycle where
// byte_vld & byte_rdy. Once byte_vld rises, byte_data/byte_sop/byte_eop
// hold steady until that byte transfers.
module eth_payload_byte_reader #(
  parameter int LEN_W   = 16,
  parameter int MIN_LEN = 46
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             fifo_rd_vld,
  input  logic [31:0]      fifo_rd_data,
  output logic             fifo_rd_en,
  output logic [7:0]       byte_data,
  output logic             byte_vld,
  input  logic             byte_rdy,
  output logic             byte_sop,
  output logic             byte_eop,
  output logic [1:0]       o_dbg_state
);

`ifdef ETH_MIN_PAYLOAD_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef ETH_MIN_PAYLOAD_PAD_EN
    S_PAD  = 2'd2,
`endif
    S_RUN  = 2'd1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [LEN_W-1:0] r_len;        // latched packet length
  logic [LEN_W-1:0] r_load_left;  // payload bytes not yet popped from the FIFO
  logic [LEN_W-1:0] r_bytes_left; // payload bytes not yet transferred
  logic [31:0]      r_word;       // hold register
  logic [1:0]       r_idx;        // next byte to emit from r_word
  logic [1:0]       r_last_idx;   // last used byte in r_word
  logic             r_hold_vld;   // r_word still has bytes to emit
  logic             r_sop_pend;   // first byte of the packet not yet transferred

  logic             w_start_ok;
  logic             w_in_pad;
  logic             w_pad_last;
  logic             w_hold_xfer;
  logic             w_xfer;
  logic             w_last_in_word;
  logic             w_data_last;
  logic             w_short;
  logic             w_data_eop;
  logic             w_pop;
  logic [2:0]       w_word_bytes;
  logic [7:0]       w_byte_sel;

`ifdef ETH_MIN_PAYLOAD_PAD_EN
  logic [LEN_W-1:0] r_pad_left;   // pad bytes still to emit
  assign w_in_pad   = (r_state == S_PAD);
  assign w_pad_last = (r_pad_left == LEN_W'(1));
`else
  assign w_in_pad   = 1'b0;
  assign w_pad_last = 1'b0;
`endif

  assign w_start_ok     = start && (r_state == S_IDLE) && (len != '0);
  assign w_hold_xfer    = r_hold_vld && byte_rdy;
  assign w_xfer         = byte_vld && byte_rdy;
  assign w_last_in_word = (r_idx == r_last_idx);
  assign w_data_last    = (r_bytes_left == LEN_W'(1));
  assign w_short        = (r_len < LEN_W'(MIN_LEN));
  // When padding follows, the last data byte is not the end of the frame.
  assign w_data_eop     = w_data_last && !(PAD_EN && w_short);

  // Refill the hold register when it is empty or emptying this cycle.
  assign fifo_rd_en = (r_state == S_RUN) && (r_load_left != '0) &&
                      (!r_hold_vld || (w_hold_xfer && w_last_in_word));
  assign w_pop      = fifo_rd_en && fifo_rd_vld;

  // Used bytes in the word being popped: 4, or the remainder for the tail.
  assign w_word_bytes = (r_load_left >= LEN_W'(4)) ? 3'd4 : {1'b0, r_load_left[1:0]};

  assign busy        = (r_state != S_IDLE);
  assign byte_vld    = r_hold_vld || w_in_pad;
  assign byte_sop    = byte_vld && r_sop_pend;
  assign byte_eop    = (r_hold_vld && w_data_eop) || (w_in_pad && w_pad_last);
  assign o_dbg_state = r_state;

  // Select the current byte of the hold register, big-endian order.
  always_comb begin
    w_byte_sel = 8'h00;
    case (r_idx)
      2'd0:    w_byte_sel = r_word[31:24];
      2'd1:    w_byte_sel = r_word[23:16];
      2'd2:    w_byte_sel = r_word[15:8];
      default: w_byte_sel = r_word[7:0];
    endcase
    byte_data = w_in_pad ? 8'h00 : w_byte_sel;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic: leave RUN when the last data byte transfers.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_start_ok) w_next_state = S_RUN;
      S_RUN: begin
        if (w_hold_xfer && w_data_last) begin
`ifdef ETH_MIN_PAYLOAD_PAD_EN
          w_next_state = w_short ? S_PAD : S_IDLE;
`else
          w_next_state = S_IDLE;
`endif
        end
      end
`ifdef ETH_MIN_PAYLOAD_PAD_EN
      S_PAD: if (w_xfer && w_pad_last) w_next_state = S_IDLE;
`endif
      default: w_next_state = S_IDLE;
    endcase
  end

  // Packet counters, hold register and byte index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len        <= '0;
      r_load_left  <= '0;
      r_bytes_left <= '0;
      r_word       <= '0;
      r_idx        <= '0;
      r_last_idx   <= '0;
      r_hold_vld   <= 1'b0;
      r_sop_pend   <= 1'b0;
    end else if (w_start_ok) begin
      r_len        <= len;
      r_load_left  <= len;
      r_bytes_left <= len;
      r_idx        <= '0;
      r_hold_vld   <= 1'b0;
      r_sop_pend   <= 1'b1;
    end else begin
      if (w_pop) begin
        r_load_left <= r_load_left - LEN_W'(w_word_bytes);
        r_word      <= fifo_rd_data;
        r_idx       <= 2'd0;
        r_last_idx  <= w_word_bytes[1:0] - 2'd1;
        r_hold_vld  <= 1'b1;
      end else if (w_hold_xfer) begin
        if (w_last_in_word) r_hold_vld <= 1'b0;
        else                r_idx      <= r_idx + 2'd1;
      end
      if (w_hold_xfer) r_bytes_left <= r_bytes_left - LEN_W'(1);
      if (w_xfer)      r_sop_pend   <= 1'b0;
    end
  end

`ifdef ETH_MIN_PAYLOAD_PAD_EN
  // Pad byte counter, loaded at start and counted down in PAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_pad_left <= '0;
    else if (w_start_ok)          r_pad_left <= LEN_W'(MIN_LEN) - len;
    else if (w_in_pad && w_xfer)  r_pad_left <= r_pad_left - LEN_W'(1);
  end
`endif

endmodule

// File: tb/tb_eth_payload_byte_reader.sv
// Directed bench for eth_payload_byte_reader: FIFO model, byte scoreboard,
// stall-stability checks and pop counting. Expected bytes are built from
// the hand-written FIFO words and packet lengths.
module tb_eth_payload_byte_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] len;
  logic        busy;
  logic        fifo_rd_vld;
  logic [31:0] fifo_rd_data;
  logic        fifo_rd_en;
  logic [7:0]  byte_data;
  logic        byte_vld;
  logic        byte_rdy;
  logic        byte_sop;
  logic        byte_eop;
  logic [1:0]  dbg_state;

  eth_payload_byte_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .len          (len),
    .busy         (busy),
    .fifo_rd_vld  (fifo_rd_vld),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .byte_data    (byte_data),
    .byte_vld     (byte_vld),
    .byte_rdy     (byte_rdy),
    .byte_sop     (byte_sop),
    .byte_eop     (byte_eop),
    .o_dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int pops         = 0;
  int first_pop_cyc, first_vld_cyc, first_xfer_cyc, last_xfer_cyc;
  int exp_total;
  int gap_lo_cnt;

  logic [31:0] fifo_q[$];
  logic [9:0]  exp_q[$];   // {sop, eop, data}

  logic       prev_stall;
  logic [7:0] prev_data;
  logic       prev_sop, prev_eop;
  logic       smp_vld;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected byte stream for one packet built from up to three words.
  task automatic add_exp(input int ln, input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2);
    logic [31:0] w[3];
    logic [31:0] sel;
    logic [7:0]  b;
    int total;
    w[0] = w0; w[1] = w1; w[2] = w2;
    total = ln;
`ifdef ETH_MIN_PAYLOAD_PAD_EN
    if (ln < 46) total = 46;
`endif
    exp_total = total;
    for (int i = 0; i < total; i++) begin
      if (i < ln) begin
        sel = w[i / 4] >> (8 * (3 - (i % 4)));
        b   = sel[7:0];
      end else begin
        b = 8'h00;
      end
      exp_q.push_back({(i == 0), (i == total - 1), b});
    end
  endtask

  // Driver + monitor for one clock cycle; starts and ends at a negedge.
  task automatic step(input logic rdy, input logic gate, input logic st, input logic [15:0] ln);
    logic       pop;
    logic [9:0] e;
    byte_rdy     = rdy;
    start        = st;
    len          = ln;
    fifo_rd_vld  = gate && (fifo_q.size() > 0);
    fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
    #1;
    smp_vld = byte_vld;
    if (prev_stall) begin
      check("stall_vld", byte_vld, 1);
      check("stall_data", byte_data, prev_data);
      check("stall_sop", byte_sop, prev_sop);
      check("stall_eop", byte_eop, prev_eop);
    end
    pop = fifo_rd_en && fifo_rd_vld;
    if (pop) begin
      pops++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
    end
    if (byte_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (byte_vld && byte_rdy) begin
      tests_run++;
      assert (exp_q.size() != 0) else begin
        tests_failed++;
        $error("FAIL extra_byte: observed %0h expected none", byte_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("byte_data", byte_data, e[7:0]);
        check("byte_sop", byte_sop, e[9]);
        check("byte_eop", byte_eop, e[8]);
      end
      if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
      last_xfer_cyc = cyc;
    end
    prev_stall = byte_vld && !byte_rdy;
    prev_data  = byte_data;
    prev_sop   = byte_sop;
    prev_eop   = byte_eop;
    @(posedge clk);
    if (pop) void'(fifo_q.pop_front());
    cyc++;
    @(negedge clk);
  endtask

  // Start a packet and drive it until the scoreboard drains.
  task automatic run_pkt(input logic [15:0] ln, input bit alt_rdy, input bit gap,
                         input bit spam, input int exp_pops);
    int   p0;
    int   gap_cnt;
    logic rdy, gate;
    p0 = pops; gap_cnt = 0; gap_lo_cnt = 0;
    first_pop_cyc = -1; first_vld_cyc = -1; first_xfer_cyc = -1; last_xfer_cyc = -1;
    step(1'b1, 1'b1, 1'b1, ln);
    check("busy_after_start", busy, 1);
    for (int c = 0; c < 400 && exp_q.size() != 0; c++) begin
      rdy  = alt_rdy ? ((c % 2) == 0) : 1'b1;
      gate = 1'b1;
      if (gap && (pops - p0) == 1 && gap_cnt < 5) begin
        gate = 1'b0;
        gap_cnt++;
      end
      step(rdy, gate, spam, 16'd4);
      if (!gate && !smp_vld) gap_lo_cnt++;
    end
    check("pkt_bytes_left", exp_q.size(), 0);
    start = 1'b0;
    #1;
    check("busy_after_eop", busy, 0);
    check("rd_en_idle", fifo_rd_en, 0);
    check("pop_count", pops - p0, exp_pops);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; len = '0; byte_rdy = 1'b0;
    fifo_rd_vld = 1'b0; fifo_rd_data = '0;
    prev_stall = 1'b0; prev_data = '0; prev_sop = 1'b0; prev_eop = 1'b0; smp_vld = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_vld", byte_vld, 0);
    check("rst_sop", byte_sop, 0);
    check("rst_eop", byte_eop, 0);
    check("rst_data", byte_data, 8'h00);
    check("rst_state", dbg_state, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // len=8, full rate, start held high the whole packet (must be ignored)
    fifo_q.push_back(32'h01020304); fifo_q.push_back(32'h05060708);
    add_exp(8, 32'h01020304, 32'h05060708, 32'h0);
    run_pkt(16'd8, 1'b0, 1'b0, 1'b1, 2);
    check("first_vld_latency", first_vld_cyc - first_pop_cyc, 1);
    check("back_to_back", last_xfer_cyc - first_xfer_cyc + 1, exp_total);

    // len=5 then len=4: tail bytes of 0xEEFF0011 discarded
    fifo_q.push_back(32'hAABBCCDD); fifo_q.push_back(32'hEEFF0011);
    fifo_q.push_back(32'h12345678);
    add_exp(5, 32'hAABBCCDD, 32'hEEFF0011, 32'h0);
    run_pkt(16'd5, 1'b0, 1'b0, 1'b0, 2);
    add_exp(4, 32'h12345678, 32'h0, 32'h0);
    run_pkt(16'd4, 1'b0, 1'b0, 1'b0, 1);
    check("fifo_drained", fifo_q.size(), 0);

    // len=8 with byte_rdy 1,0,1,0...
    fifo_q.push_back(32'hC0C1C2C3); fifo_q.push_back(32'hC4C5C6C7);
    add_exp(8, 32'hC0C1C2C3, 32'hC4C5C6C7, 32'h0);
    run_pkt(16'd8, 1'b1, 1'b0, 1'b0, 2);

    // len=8 with FIFO invalid for 5 cycles after the first pop
    fifo_q.push_back(32'h11223344); fifo_q.push_back(32'h55667788);
    add_exp(8, 32'h11223344, 32'h55667788, 32'h0);
    run_pkt(16'd8, 1'b0, 1'b1, 1'b0, 2);
    check("gap_seen", (gap_lo_cnt > 0), 1);

    // len=10, pad or no pad depending on build
    fifo_q.push_back(32'h0A0B0C0D); fifo_q.push_back(32'h0E0F1011);
    fifo_q.push_back(32'h1213FFFF);
    add_exp(10, 32'h0A0B0C0D, 32'h0E0F1011, 32'h1213FFFF);
    run_pkt(16'd10, 1'b0, 1'b0, 1'b0, 3);
    check("len10_fifo_drained", fifo_q.size(), 0);

    // start with len=0 is ignored
    begin
      int p0;
      p0 = pops;
      fifo_q.push_back(32'hDEADBEEF);
      step(1'b1, 1'b1, 1'b1, 16'd0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 16'd0);
      check("len0_busy", busy, 0);
      check("len0_pops", pops - p0, 0);
      check("len0_state", dbg_state, 0);
      fifo_q.delete();
    end

    // reset mid-packet: immediate clear, then no further pops
    begin
      int p0;
      fifo_q.push_back(32'hA1A2A3A4); fifo_q.push_back(32'hA5A6A7A8);
      step(1'b1, 1'b1, 1'b1, 16'd8);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'd0);
      check("mid_vld_before_rst", byte_vld, 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_vld", byte_vld, 0);
      check("mid_rst_rd_en", fifo_rd_en, 0);
      check("mid_rst_data", byte_data, 8'h00);
      check("mid_rst_sop", byte_sop, 0);
      check("mid_rst_eop", byte_eop, 0);
      check("mid_rst_state", dbg_state, 0);
      @(negedge clk);
      rst_n = 1'b1;
      prev_stall = 1'b0;
      p0 = pops;
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 16'd0);
      check("post_rst_pops", pops - p0, 0);
      check("post_rst_busy", busy, 0);
      check("post_rst_vld", byte_vld, 0);
      fifo_q.delete();
      exp_q.delete();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/eth_payload_byte_reader.md
ETH_PAYLOAD_BYTE_READER -- requirements
Module: eth_payload_byte_reader

Interface
REQ-001 SHALL have parameter LEN_W, default 16, meaning the width of the packet byte-length field.
REQ-002 SHALL have parameter MIN_LEN, default 46, meaning the minimum payload byte count; used only under REQ-029.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, single-cycle packet request.
REQ-006 SHALL have port len, input, LEN_W, payload byte count, sampled with start.
REQ-007 SHALL have port busy, output, 1, high while a packet is in progress.
REQ-008 SHALL have port fifo_rd_vld, input, 1, prefetch-FIFO output word valid.
REQ-009 SHALL have port fifo_rd_data, input, 32, prefetch-FIFO output word, valid combinationally with fifo_rd_vld.
REQ-010 SHALL have port fifo_rd_en, output, 1, FIFO pop; a pop occurs when fifo_rd_vld and fifo_rd_en are both high.
REQ-011 SHALL have port byte_data, output, 8, output payload byte.
REQ-012 SHALL have port byte_vld, output, 1, byte_data valid.
REQ-013 SHALL have port byte_rdy, input, 1, downstream accept; a byte transfers when byte_vld and byte_rdy are both high.
REQ-014 SHALL have ports byte_sop and byte_eop, outputs, 1 each, first and last byte markers, qualified by byte_vld.

Function
REQ-015 SHALL have states IDLE and RUN (plus PAD under REQ-029); IDLE moves to RUN on start with len!=0; start with len==0, or any start outside IDLE, SHALL be ignored.
REQ-016 SHALL latch len on start and set busy in the following cycle.
REQ-017 SHALL pop exactly ceil(len/4) words per packet, never more and never fewer.
REQ-018 SHALL hold one 32-bit word register plus a 2-bit byte index; bytes are emitted big-endian, bits [31:24] first.
REQ-019 SHALL drive fifo_rd_en = RUN & words_left!=0 & (hold register empty, or its last used byte transfers this cycle).
REQ-020 SHALL emit the first byte_vld one cycle after the first pop, a registered path.
REQ-021 SHALL sustain one byte per cycle with byte_rdy high and a non-empty FIFO, with no bubble at word boundaries.
REQ-022 SHALL keep byte_data, byte_sop and byte_eop stable while byte_vld & ~byte_rdy, and SHALL not drop byte_vld until the byte transfers.
REQ-023 SHALL, for a final word holding len mod 4 != 0 used bytes, discard the unused low bytes; the next packet starts on a fresh word.
REQ-024 SHALL assert byte_sop on byte 1 and byte_eop on the last byte, and both together for len==1.
REQ-025 SHALL return to IDLE and clear busy in the cycle after the byte_eop transfer; start in that same cycle SHALL be ignored.
REQ-026 SHALL, when fifo_rd_vld is low mid-packet, deassert byte_vld once the held bytes are exhausted and resume without data loss.

Reset
REQ-027 SHALL, on rst_n low, immediately and asynchronously set the state to IDLE and clear busy, fifo_rd_en, byte_vld, byte_sop, byte_eop, byte_data (to 8'h00), the counters and the hold register.
REQ-028 SHALL, after reset asserted mid-packet, abandon the packet with no further pops and take no action until the next start; leftover FIFO words are the system's concern.

Configuration
REQ-029 SHALL provide macro ETH_MIN_PAYLOAD_PAD_EN; when defined and len<MIN_LEN, SHALL, after the len data bytes, enter PAD and emit 8'h00 bytes until MIN_LEN bytes total, with byte_eop on the last pad byte and pops still ceil(len/4); when undefined, PAD SHALL be absent and byte_eop SHALL fall on byte len.

Verification
REQ-030 SHALL cover: len=8, FIFO words 0x01020304 and 0x05060708, byte_rdy=1 -> bytes 01..08 in 8 consecutive cycles, sop on 01, eop on 08, exactly 2 pops.
REQ-031 SHALL cover: len=5, words 0xAABBCCDD and 0xEEFF0011, then a len=4 packet with word 0x12345678 -> AA BB CC DD EE with eop on EE, then 12 34 56 78; 3 pops total.
REQ-032 SHALL cover: len=8 with byte_rdy pattern 1,0,1,0... -> byte_data constant during every stalled cycle; all 8 bytes delivered in order.
REQ-033 SHALL cover: fifo_rd_vld low for 5 cycles after the first word -> 4 bytes, then a byte_vld gap, no pop while invalid, then bytes resume in order.
REQ-034 SHALL cover: start with len=0, and start while busy -> ignored, no pops; rst_n pulsed low mid-packet -> all outputs 0 at once, IDLE.
REQ-035 SHALL cover: len=10 with the macro defined -> 46 bytes, bytes 11..46 all 00, eop on byte 46, 3 pops; macro undefined -> 10 bytes, eop on byte 10.
